inst_fetch: RTL
===============

Name: inst_fetch

Overview:
- Instruction fetch stage for the MCU51 core, directly downstream of the byte-wide program ROM.
- Drives the ROM address and active-low chip select, then reads 1–3 bytes per instruction using the 8051 opcode length table.
- Presents the assembled instruction (opcode, operands, PC, next PC) to the decoder over a valid/ready handshake.
- Accepts PC redirects from the execute stage for jumps, calls and returns.

Parameters:
ADDRWIDTH, 8, ROM address width; PC arithmetic wraps modulo 2^ADDRWIDTH
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  clock; all state updates on posedge (ROM updates its data register on negedge)
rst  in  1  synchronous active-high reset
rom_cs  out  1  ROM chip select, active low
rom_addr  out  ADDRWIDTH  ROM byte address (registered)
rom_data  in  8  ROM byte; valid at the posedge following an address change
redirect  in  1  one-cycle pulse: load new PC
redirect_pc  in  ADDRWIDTH  target PC, sampled when redirect=1
inst_valid  out  1  assembled instruction available
inst_ready  in  1  decoder accepts; handshake when inst_valid & inst_ready
inst_opcode  out  8  opcode byte
inst_op1  out  8  second byte (0 if len<2)
inst_op2  out  8  third byte (0 if len<3)
inst_len  out  2  instruction length, 1..3
inst_pc  out  ADDRWIDTH  address of the opcode
inst_next_pc  out  ADDRWIDTH  inst_pc+inst_len, wrapped

Behaviour:
- Reset (rst=1 at posedge):
  - state=S_OP, pc=rom_addr=RESET_PC.
  - inst_valid=0; inst_opcode/op1/op2=0, inst_len=1, inst_pc=inst_next_pc=RESET_PC.
  - rom_cs=1 while rst is high.
- rom_cs is a combinational decode: 0 in S_OP, S_B1 and S_B2; 1 in S_OUT and during rst.
- Read latency: rom_addr set at posedge k; rom_data sampled at posedge k+1. Each byte costs 1 cycle.
- S_OP (capture opcode):
  - Capture opcode = rom_data and len = LEN(rom_data); clear op1/op2.
  - len=1 -> S_OUT.
  - Otherwise rom_addr=pc+1 -> S_B1.
- S_B1 (capture first operand):
  - op1 = rom_data.
  - len=3 -> rom_addr=pc+2, S_B2.
  - Otherwise -> S_OUT.
- S_B2 (capture second operand): op2 = rom_data -> S_OUT.
- S_OUT (present instruction):
  - inst_valid=1; all inst_* outputs are held stable until handshake.
  - On handshake: pc = pc+len, rom_addr = pc+len, inst_valid=0 next cycle -> S_OP.
- Throughput with inst_ready tied high: len+1 cycles per instruction.
- Address arithmetic is modulo 2^ADDRWIDTH (e.g. FF+1=00).
- Redirect:
  - Highest priority after rst, in any state.
  - Next edge: pc = rom_addr = redirect_pc, state=S_OP, inst_valid=0; any partial or held instruction is discarded.
  - If redirect coincides with a handshake, the handshake completes (the decoder owns that instruction) but the PC comes from redirect_pc.
- rst asserted mid-fetch: aborts the fetch; state returns to reset values at that edge.
- Length table LEN, all opcodes in hex:
  - 3 bytes: 02 10 12 20 30 43 53 63 75 85 90 B4–BF D5.
  - 2 bytes: every x1; 05 15 25 35 45 55 65 95 C5 E5 F5; 24 34 44 54 64 74 94; 40 50 60 70 80 A0 B0 C0 D0; 42 52 62 72 82 92 A2 B2 C2 D2; 76–7F; 86–8F; A6–AF; D8–DF.
  - 1 byte: all other opcodes, including reserved A5.

Decomposition:
- Shared package mcu51_pkg:
  - fetch state enum (S_OP, S_B1, S_B2, S_OUT);
  - default ADDRWIDTH;
  - opcode-length constants.
- Sub-module mcu51_insn_len: purely combinational, 8-bit opcode -> 2-bit length. It is reused by the decoder.

Test Plan:
- Reset, then program ROM (00:02 01:00 02:C2), inst_ready=1 -> first instruction: opcode 02, op1 00, op2 C2, len 3, inst_pc 00, next_pc 03, valid 3 cycles after reset release. The next instruction comes from 03: opcode 00, len 1.
- Redirect to C2 (C2:74 C3:FF C4:04 C5:40 C6:89) -> sequence: 74/FF len2 pc C2; 04 len1 pc C4; 40/89 len2 pc C5, next_pc C7.
- inst_ready=0 for 5 cycles while valid -> outputs stable, rom_cs=1, no address change; on ready the PC advances by len.
- Wrap: redirect to FE with bench ROM FE:75 FF:08 00:40 -> opcode 75, op1 08, op2 40, len 3, inst_pc FE, next_pc 01; rom_addr sequence FE, FF, 00.
- Redirect during S_B1 of a 3-byte instruction, and redirect in the same cycle as a handshake -> partial instruction dropped, no spurious valid, next opcode fetched at redirect_pc.
- rst pulse in S_B2 -> next cycle inst_valid=0, rom_addr=RESET_PC, fetch restarts cleanly.

Source files
------------

// File: rtl/mcu51_pkg.sv
// Shared definitions for the MCU51 fetch/decode front end.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: fetch FSM state enum, default ROM address width, opcode length codes.
package mcu51_pkg;

   localparam int ADDRWIDTH_DEF = 8;

   // Fetch sequencer states: opcode byte, first operand, second operand, present.
   typedef enum logic [1:0] {
      S_OP  = 2'd0,
      S_B1  = 2'd1,
      S_B2  = 2'd2,
      S_OUT = 2'd3
   } fetch_state_e;

   // Instruction length codes as produced by mcu51_insn_len.
   localparam logic [1:0] INSN_LEN1 = 2'd1;
   localparam logic [1:0] INSN_LEN2 = 2'd2;
   localparam logic [1:0] INSN_LEN3 = 2'd3;

endpackage

// File: rtl/inst_fetch_if.sv
// Bundle of the fetch stage's ROM port, redirect port and decoder handshake.
// Latency: n/a (wiring only).
// Backpressure: inst_valid/inst_ready handshake toward the decoder; the ROM has none.
//
// master: fetch stage (drives rom_cs/rom_addr and inst_*).
// slave : ROM + execute + decoder side (drives rom_data, redirect, inst_ready).
interface inst_fetch_if
   import mcu51_pkg::*;
#(
   parameter int ADDRWIDTH = ADDRWIDTH_DEF
) ();

   logic                 rom_cs;
   logic [ADDRWIDTH-1:0] rom_addr;
   logic [7:0]           rom_data;
   logic                 redirect;
   logic [ADDRWIDTH-1:0] redirect_pc;
   logic                 inst_valid;
   logic                 inst_ready;
   logic [7:0]           inst_opcode;
   logic [7:0]           inst_op1;
   logic [7:0]           inst_op2;
   logic [1:0]           inst_len;
   logic [ADDRWIDTH-1:0] inst_pc;
   logic [ADDRWIDTH-1:0] inst_next_pc;

   modport master (
      output rom_cs, rom_addr,
      input  rom_data,
      input  redirect, redirect_pc,
      output inst_valid, inst_opcode, inst_op1, inst_op2, inst_len, inst_pc, inst_next_pc,
      input  inst_ready
   );

   modport slave (
      input  rom_cs, rom_addr,
      output rom_data,
      output redirect, redirect_pc,
      input  inst_valid, inst_opcode, inst_op1, inst_op2, inst_len, inst_pc, inst_next_pc,
      output inst_ready
   );

endinterface

// File: rtl/mcu51_insn_len.sv
// 8051 opcode -> instruction length (1..3 bytes); shared by fetch and decode.
// Latency: purely combinational.
// Backpressure: none.
//
// Ports: opcode (in, 8) ; len (out, 2).
module mcu51_insn_len
   import mcu51_pkg::*;
(
   input  logic [7:0] opcode,
   output logic [1:0] len
);

   always_comb begin
      len = INSN_LEN1;
      // Every xx1 opcode (AJMP/ACALL page forms) carries one address byte.
      if (opcode[3:0] == 4'h1) begin
         len = INSN_LEN2;
      end
      // First match wins: three-byte forms are listed before neighbouring two-byte ranges.
      casez (opcode)
         8'h02, 8'h10, 8'h12, 8'h20, 8'h30, 8'h43, 8'h53, 8'h63,
         8'h75, 8'h85, 8'h90, 8'hD5,
         8'b1011_01??, 8'b1011_1???:                      // B4..BF
            len = INSN_LEN3;
         8'h05, 8'h15, 8'h25, 8'h35, 8'h45, 8'h55, 8'h65, 8'h95,
         8'hC5, 8'hE5, 8'hF5,
         8'h24, 8'h34, 8'h44, 8'h54, 8'h64, 8'h74, 8'h94,
         8'h40, 8'h50, 8'h60, 8'h70, 8'h80, 8'hA0, 8'hB0, 8'hC0, 8'hD0,
         8'h42, 8'h52, 8'h62, 8'h72, 8'h82, 8'h92, 8'hA2, 8'hB2, 8'hC2, 8'hD2,
         8'b0111_011?, 8'b0111_1???,                      // 76..7F
         8'b1000_011?, 8'b1000_1???,                      // 86..8F
         8'b1010_011?, 8'b1010_1???,                      // A6..AF
         8'b1101_1???:                                    // D8..DF
            len = INSN_LEN2;
         default: ;
      endcase
   end

endmodule

// File: rtl/inst_fetch.sv
// MCU51 fetch stage: reads 1..3 ROM bytes per instruction and hands it to the decoder.
// Latency: len cycles from opcode address to inst_valid; len+1 cycles/insn with ready high.
// Backpressure: holds the instruction (ROM deselected) until inst_valid & inst_ready.
//
// Ports: clk, rst (sync, active high); bus (inst_fetch_if.master): rom_cs/rom_addr/rom_data,
//        redirect/redirect_pc, inst_valid/inst_ready, inst_opcode/op1/op2/len/pc/next_pc.
module inst_fetch
   import mcu51_pkg::*;
#(
   parameter int                   ADDRWIDTH = ADDRWIDTH_DEF,   // must match the bus instance
   parameter logic [ADDRWIDTH-1:0] RESET_PC  = '0
) (
   input  logic          clk,
   input  logic          rst,
   inst_fetch_if.master  bus
);

   typedef logic [ADDRWIDTH-1:0] addr_t;

   fetch_state_e state_q, state_d;
   addr_t        pc_q, pc_d;
   addr_t        rom_addr_q, rom_addr_d;
   addr_t        next_pc_q, next_pc_d;
   logic [7:0]   opcode_q, opcode_d;
   logic [7:0]   op1_q, op1_d;
   logic [7:0]   op2_q, op2_d;
   logic [1:0]   len_q, len_d;
   logic         valid_q, valid_d;

   logic [1:0]   rom_len;
   logic         handshake;

   mcu51_insn_len u_len (
      .opcode (bus.rom_data),
      .len    (rom_len)
   );

   assign handshake = valid_q & bus.inst_ready;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      rom_addr_d = rom_addr_q;
      next_pc_d  = next_pc_q;
      opcode_d   = opcode_q;
      op1_d      = op1_q;
      op2_d      = op2_q;
      len_d      = len_q;
      valid_d    = valid_q;

      case (state_q)
         S_OP: begin
            opcode_d  = bus.rom_data;
            len_d     = rom_len;
            op1_d     = 8'h00;
            op2_d     = 8'h00;
            next_pc_d = pc_q + addr_t'(rom_len);
            if (rom_len == INSN_LEN1) begin
               valid_d = 1'b1;
               state_d = S_OUT;
            end else begin
               rom_addr_d = pc_q + addr_t'(1);
               state_d    = S_B1;
            end
         end
         S_B1: begin
            op1_d = bus.rom_data;
            if (len_q == INSN_LEN3) begin
               rom_addr_d = pc_q + addr_t'(2);
               state_d    = S_B2;
            end else begin
               valid_d = 1'b1;
               state_d = S_OUT;
            end
         end
         S_B2: begin
            op2_d   = bus.rom_data;
            valid_d = 1'b1;
            state_d = S_OUT;
         end
         S_OUT: begin
            if (handshake) begin
               pc_d       = next_pc_q;
               rom_addr_d = next_pc_q;
               valid_d    = 1'b0;
               state_d    = S_OP;
            end
         end
         default: state_d = S_OP;
      endcase

      // A redirect discards whatever is in flight; a coincident handshake still
      // counts on the decoder side, only the successor PC is overridden here.
      if (bus.redirect) begin
         pc_d       = bus.redirect_pc;
         rom_addr_d = bus.redirect_pc;
         valid_d    = 1'b0;
         state_d    = S_OP;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_OP;
         pc_q       <= RESET_PC;
         rom_addr_q <= RESET_PC;
         next_pc_q  <= RESET_PC;
         opcode_q   <= 8'h00;
         op1_q      <= 8'h00;
         op2_q      <= 8'h00;
         len_q      <= INSN_LEN1;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         rom_addr_q <= rom_addr_d;
         next_pc_q  <= next_pc_d;
         opcode_q   <= opcode_d;
         op1_q      <= op1_d;
         op2_q      <= op2_d;
         len_q      <= len_d;
         valid_q    <= valid_d;
      end
   end

   // Chip select is deselected while the instruction is parked and during reset.
   assign bus.rom_cs       = rst | (state_q == S_OUT);
   assign bus.rom_addr     = rom_addr_q;
   assign bus.inst_valid   = valid_q;
   assign bus.inst_opcode  = opcode_q;
   assign bus.inst_op1     = op1_q;
   assign bus.inst_op2     = op2_q;
   assign bus.inst_len     = len_q;
   assign bus.inst_pc      = pc_q;
   assign bus.inst_next_pc = next_pc_q;

endmodule
